drop_scheduler: RTL and testbench

//  Sequences the falling-letter columns of the Flippy Bit game.
//  - Generates the shared fall-step tick; the tick rate rises with score.
//  - Decides when a new letter is spawned and which idle column receives it (round-robin).
//  - Supplies each new letter's 8-bit value from one shared LFSR.
//  - Sits between the game state machine (score, reset_signal) and the column instances.

---
 rtl/flippy_pkg.sv | 24 ++
 rtl/drop_scheduler_if.sv | 37 +++
 rtl/drop_scheduler_lfsr8.sv | 32 +++
 rtl/drop_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_drop_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flippy_pkg.sv
// -----------------------------------------------------------------------------
// flippy_pkg
//   Shared constants and types for the Flippy Bit game slice.
//   - DEF_NUM_COLS : default number of falling-letter columns
//   - ROWS, COLS   : playfield geometry
//   - LFSR_TAPS    : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   - sched_state_t: drop_scheduler FSM encoding
// -----------------------------------------------------------------------------
package flippy_pkg;

  localparam int DEF_NUM_COLS = 3;
  localparam int ROWS = 30;
  localparam int COLS = 40;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GAP = 2'd1,
    ARB      = 2'd2,
    ISSUE    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/drop_scheduler_if.sv
// -----------------------------------------------------------------------------
// drop_scheduler_if
//   Spawn bus between drop_scheduler (master) and the column instances (slave).
//   Signals:
//     col_busy    columns -> sched  bit i = 1: column i holds an active letter
//     spawn_ready columns -> sched  bit i = 1: column i accepts a spawn
//     spawn_valid sched -> columns  one-hot spawn request
//     spawn_value sched -> columns  letter value carried by the request
//
//   Handshake: a transfer to column k happens on a rising clock edge where
//   spawn_valid[k] and spawn_ready[k] are both 1. Once spawn_valid is raised,
//   spawn_valid and spawn_value stay unchanged until that transfer (only a
//   reset may withdraw the request). spawn_ready may be driven independently
//   of spawn_valid.
// -----------------------------------------------------------------------------
interface drop_scheduler_if #(
  parameter int NUM_COLS = flippy_pkg::DEF_NUM_COLS
);
  logic [NUM_COLS-1:0] col_busy;
  logic [NUM_COLS-1:0] spawn_ready;
  logic [NUM_COLS-1:0] spawn_valid;
  logic [7:0]          spawn_value;

  modport master (
    output spawn_valid,
    output spawn_value,
    input  spawn_ready,
    input  col_busy
  );

  modport slave (
    input  spawn_valid,
    input  spawn_value,
    output spawn_ready,
    output col_busy
  );
endinterface

// File: rtl/drop_scheduler_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
//   8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1 (maximal length), so a
//   non-zero seed never reaches 0. Advances every clock cycle.
//   Ports:
//     clock         in   system clock
//     reset_signal  in   synchronous active-high reset, loads seed
//     seed          in   reset value (must be non-zero)
//     out           out  current LFSR state
// -----------------------------------------------------------------------------
module lfsr8
  import flippy_pkg::*;
(
  input  logic       clock,
  input  logic       reset_signal,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  logic feedback;

  assign feedback = ^(out & LFSR_TAPS);

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      out <= seed;
    end else begin
      out <= {out[6:0], feedback};
    end
  end

endmodule

// File: rtl/drop_scheduler.sv
// -----------------------------------------------------------------------------
// drop_scheduler
//   Sequences the falling-letter columns of Flippy Bit: generates the shared
//   fall-step tick (faster with score), picks an idle column round-robin for
//   each new letter and supplies the letter value from a shared LFSR.
//   Optional feature macro: DROP_SCHED_PAUSE_EN (adds the pause input).
//   Ports:
//     clock         in   system clock
//     reset_signal  in   synchronous active-high reset
//     enable        in   game running; 0 returns the FSM to IDLE
//     score         in   current score (unsigned)
//     pause         in   (DROP_SCHED_PAUSE_EN only) freeze timing and FSM
//     bus           master modport of drop_scheduler_if (spawn handshake)
//     step_tick     out  one-cycle pulse; all columns advance one row
//     level         out  speed level, min(score/SCORE_STEP, 15), registered
//     dbg_state     out  FSM state
//     dbg_rr_ptr    out  round-robin start column
//     dbg_lfsr      out  current LFSR value
// -----------------------------------------------------------------------------
module drop_scheduler
  import flippy_pkg::*;
#(
  parameter int         NUM_COLS    = DEF_NUM_COLS,
  parameter int         BASE_PERIOD = 25_000_000,
  parameter int         MIN_PERIOD  = 3_125_000,
  parameter int         SPEEDUP     = 1_500_000,
  parameter int         SCORE_STEP  = 8,
  parameter int         SPAWN_GAP   = 4,
  parameter logic [7:0] LFSR_SEED   = 8'hA5,
  localparam int        PTR_W       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic             enable,
  input  logic [7:0]       score,
`ifdef DROP_SCHED_PAUSE_EN
  input  logic             pause,
`endif
  drop_scheduler_if.master bus,
  output logic             step_tick,
  output logic [3:0]       level,
  output sched_state_t     dbg_state,
  output logic [PTR_W-1:0] dbg_rr_ptr,
  output logic [7:0]       dbg_lfsr
);

  localparam int GAP_W = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;

  logic pause_i;
`ifdef DROP_SCHED_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  // ---------------- LFSR ----------------
  logic [7:0] lfsr;

  lfsr8 u_lfsr (
    .clock        (clock),
    .reset_signal (reset_signal),
    .seed         (LFSR_SEED),
    .out          (lfsr)
  );

  // ---------------- level ----------------
  logic [31:0] lvl_raw;
  logic        lvl_sat;

  assign lvl_raw = 32'(score) / 32'(SCORE_STEP);
  assign lvl_sat = |lvl_raw[31:4];

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      level <= 4'd0;
    end else begin
      level <= lvl_sat ? 4'd15 : lvl_raw[3:0];
    end
  end

  // ---------------- fall-step tick ----------------
  // Saturating compare keeps the subtraction from ever going below MIN_PERIOD.
  logic [31:0] reduction;
  logic [31:0] period_p;
  logic [31:0] period_cnt;

  assign reduction = 32'(level) * 32'(SPEEDUP);
  assign period_p  = (reduction > 32'(BASE_PERIOD - MIN_PERIOD)) ?
                     32'(MIN_PERIOD) : (32'(BASE_PERIOD) - reduction);

  assign step_tick = enable && !pause_i && (period_cnt == 32'd0);

  // Level changes only reach the counter at reload.
  always_ff @(posedge clock) begin
    if (reset_signal) begin
      period_cnt <= 32'(BASE_PERIOD - 1);
    end else if (enable && !pause_i) begin
      if (period_cnt == 32'd0) begin
        period_cnt <= period_p - 32'd1;
      end else begin
        period_cnt <= period_cnt - 32'd1;
      end
    end
  end

  // ---------------- round-robin scan ----------------
  sched_state_t        state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [PTR_W-1:0]    sel_q, sel_d;
  logic [NUM_COLS-1:0] valid_q, valid_d;
  logic [7:0]          value_q, value_d;
  logic                free_found;
  logic [PTR_W-1:0]    free_idx;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_COLS) s = s - NUM_COLS;
    return PTR_W'(s);
  endfunction

  // Walk offsets from the far end down so the closest free column to rr_q wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!bus.col_busy[wrap_idx(rr_q, i)]) begin
        free_found = 1'b1;
        free_idx   = wrap_idx(rr_q, i);
      end
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        if (enable && !pause_i) begin
          state_d = WAIT_GAP;
          gap_d   = '0;
        end
      end
      WAIT_GAP: begin
        if (!pause_i) begin
          if (!enable) begin
            state_d = IDLE;
          end else if (gap_q == GAP_W'(SPAWN_GAP)) begin
            state_d = ARB;
          end else if (step_tick) begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      ARB: begin
        if (!pause_i) begin
          if (!enable) begin
            state_d = IDLE;
          end else if (free_found) begin
            valid_d = NUM_COLS'(1) << free_idx;
            value_d = lfsr;
            sel_d   = free_idx;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Pause and enable do not block a pending handshake; a tick in the
        // same cycle is swallowed by the gap clear.
        if (|(valid_q & bus.spawn_ready)) begin
          valid_d = '0;
          gap_d   = '0;
          rr_d    = (sel_q == PTR_W'(NUM_COLS - 1)) ? '0 : (sel_q + 1'b1);
          state_d = enable ? WAIT_GAP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      state_q <= IDLE;
      gap_q   <= '0;
      rr_q    <= '0;
      sel_q   <= '0;
      valid_q <= '0;
      value_q <= 8'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      value_q <= value_d;
    end
  end

  assign bus.spawn_valid = valid_q;
  assign bus.spawn_value = value_q;
  assign dbg_state       = state_q;
  assign dbg_rr_ptr      = rr_q;
  assign dbg_lfsr        = lfsr;

endmodule

// File: tb/tb_drop_scheduler.sv
// -----------------------------------------------------------------------------
// tb_drop_scheduler
//   Self-checking bench for drop_scheduler with small timing parameters
//   (BASE_PERIOD=10, MIN_PERIOD=4, SPEEDUP=2, SCORE_STEP=8, SPAWN_GAP=2).
//   Expected spawn targets go into exp_q when a scenario sets up col_busy;
//   a negedge monitor pops them when spawn_valid rises and checks the value
//   against an independent LFSR model.
// -----------------------------------------------------------------------------
module tb_drop_scheduler;
  import flippy_pkg::*;

  localparam int NC = 3;

  // ---------------- clock / reset ----------------
  logic clock        = 1'b0;
  logic reset_signal = 1'b1;
  logic enable       = 1'b0;
  logic [7:0] score  = 8'd0;
`ifdef DROP_SCHED_PAUSE_EN
  logic pause        = 1'b0;
`endif

  always #5 clock = ~clock;

  logic         step_tick;
  logic [3:0]   level;
  sched_state_t dbg_state;
  logic [1:0]   dbg_rr_ptr;
  logic [7:0]   dbg_lfsr;

  drop_scheduler_if #(.NUM_COLS(NC)) bus ();

  drop_scheduler #(
    .NUM_COLS    (NC),
    .BASE_PERIOD (10),
    .MIN_PERIOD  (4),
    .SPEEDUP     (2),
    .SCORE_STEP  (8),
    .SPAWN_GAP   (2),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clock        (clock),
    .reset_signal (reset_signal),
    .enable       (enable),
    .score        (score),
`ifdef DROP_SCHED_PAUSE_EN
    .pause        (pause),
`endif
    .bus          (bus),
    .step_tick    (step_tick),
    .level        (level),
    .dbg_state    (dbg_state),
    .dbg_rr_ptr   (dbg_rr_ptr),
    .dbg_lfsr     (dbg_lfsr)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- LFSR reference model ----------------
  logic [7:0] m_lfsr;
  logic [7:0] m_prev;

  always @(posedge clock) begin
    if (reset_signal) m_lfsr <= 8'hA5;
    else              m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_prev <= m_lfsr;
  end

  // ---------------- scoreboard ----------------
  logic [NC-1:0] exp_q[$];
  logic [NC-1:0] mon_prev_valid = '0;
  logic [NC-1:0] mon_exp;

  always @(negedge clock) begin
    if ((|bus.spawn_valid) === 1'b1 && mon_prev_valid === '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spawn_unexpected: got valid=%b, no spawn expected", bus.spawn_valid);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.spawn_valid !== mon_exp) begin
          failures++;
          $display("FAIL spawn_target: got valid=%b, want %b", bus.spawn_valid, mon_exp);
        end
        checks++;
        if (bus.spawn_value !== m_prev) begin
          failures++;
          $display("FAIL spawn_value: got %h, want %h", bus.spawn_value, m_prev);
        end
      end
    end
    mon_prev_valid = bus.spawn_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    reset_signal = 1'b1;
    enable       = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_signal = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (step_tick !== 1'b1 && n < 200);
    if (step_tick !== 1'b1) n = -1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((|bus.spawn_valid) !== 1'b1 && n < 200);
    if ((|bus.spawn_valid) !== 1'b1) n = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_signal = 1'b1;
    enable = 1'b0;
    bus.col_busy = '1;
    bus.spawn_ready = '1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.spawn_valid !== 3'b000 || step_tick !== 1'b0 || level !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b tick=%b level=%0d, want 000 0 0",
               bus.spawn_valid, step_tick, level);
    end
    checks++;
    if (dbg_state !== IDLE || dbg_rr_ptr !== 2'd0 || dbg_lfsr !== 8'hA5) begin
      failures++;
      $display("FAIL reset_state: got state=%0d rr=%0d lfsr=%h, want 0 0 a5",
               dbg_state, dbg_rr_ptr, dbg_lfsr);
    end
    reset_signal = 1'b0;
    // LFSR runs even while the FSM idles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (dbg_lfsr !== m_lfsr || dbg_lfsr === 8'h00) begin
        failures++;
        $display("FAIL lfsr_seq: cycle %0d got %h, want %h", i, dbg_lfsr, m_lfsr);
      end
    end
  endtask

  task automatic test_first_spawn();
    int n;
    do_reset();
    score = 8'd0;
    bus.col_busy = '0;
    bus.spawn_ready = '1;
    exp_q.push_back(3'b001);
    enable = 1'b1;
    wait_tick(n);
    checks++;
    if (n !== 9) begin
      failures++;
      $display("FAIL first_tick: got %0d cycles, want 9", n);
    end
    wait_tick(n);
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL base_period: got %0d cycles, want 10", n);
    end
    wait_valid(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL first_spawn_latency: got %0d cycles, want 3", n);
    end
    @(negedge clock);
    bus.col_busy = '1;
    checks++;
    if (bus.spawn_valid !== 3'b000 || dbg_rr_ptr !== 2'd1) begin
      failures++;
      $display("FAIL first_handshake: got valid=%b rr=%0d, want 000 1", bus.spawn_valid, dbg_rr_ptr);
    end
  endtask

  task automatic test_level_speed();
    int n;
    int sc[3]  = '{8, 24, 255};
    int lvl[3] = '{1, 3, 15};
    int per[3] = '{8, 4, 4};
    for (int k = 0; k < 3; k++) begin
      wait_tick(n);
      @(negedge clock);
      score = 8'(sc[k]);
      @(negedge clock);
      checks++;
      if (level !== 4'(lvl[k])) begin
        failures++;
        $display("FAIL level_%0d: got %0d, want %0d", sc[k], level, lvl[k]);
      end
      wait_tick(n);
      wait_tick(n);
      checks++;
      if (n !== per[k]) begin
        failures++;
        $display("FAIL period_%0d: got %0d cycles, want %0d", sc[k], n, per[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [NC-1:0] busy_seq[4] = '{3'b011, 3'b000, 3'b000, 3'b000};
    logic [NC-1:0] tgt_seq[4]  = '{3'b100, 3'b001, 3'b010, 3'b100};
    int            rr_seq[4]   = '{0, 1, 2, 0};
    do_reset();
    bus.spawn_ready = '1;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.col_busy = busy_seq[k];
      exp_q.push_back(tgt_seq[k]);
      wait_valid(n);
      checks++;
      if (n < 0) begin
        failures++;
        $display("FAIL rr_timeout_%0d: got no spawn, want %b", k, tgt_seq[k]);
      end
      @(negedge clock);
      checks++;
      if (dbg_rr_ptr !== 2'(rr_seq[k])) begin
        failures++;
        $display("FAIL rr_ptr_%0d: got %0d, want %0d", k, dbg_rr_ptr, rr_seq[k]);
      end
    end
    bus.col_busy = '1;
  endtask

  task automatic test_all_busy();
    int n;
    do_reset();
    bus.col_busy = '1;
    bus.spawn_ready = '1;
    enable = 1'b1;
    n = 0;
    while (dbg_state !== ARB && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (dbg_state !== ARB) begin
      failures++;
      $display("FAIL busy_reach_arb: got state=%0d, want %0d", dbg_state, ARB);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (dbg_state !== ARB || bus.spawn_valid !== 3'b000) begin
        failures++;
        $display("FAIL busy_hold_%0d: got state=%0d valid=%b, want %0d 000",
                 i, dbg_state, bus.spawn_valid, ARB);
      end
    end
    exp_q.push_back(3'b010);
    bus.col_busy = 3'b101;
    @(negedge clock);
    checks++;
    if (bus.spawn_valid !== 3'b010) begin
      failures++;
      $display("FAIL busy_release: got valid=%b, want 010", bus.spawn_valid);
    end
    bus.col_busy = '1;
  endtask

  task automatic test_hold_enable_drop();
    int n;
    int ticks;
    logic [7:0] hold_value;
    do_reset();
    bus.col_busy = '0;
    bus.spawn_ready = '0;
    exp_q.push_back(3'b001);
    enable = 1'b1;
    wait_valid(n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL hold_timeout: got no spawn, want 001");
    end
    hold_value = m_prev;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (bus.spawn_valid !== 3'b001 || bus.spawn_value !== hold_value || dbg_state !== ISSUE) begin
        failures++;
        $display("FAIL hold_stable_%0d: got valid=%b value=%h state=%0d, want 001 %h %0d",
                 i, bus.spawn_valid, bus.spawn_value, dbg_state, hold_value, ISSUE);
      end
    end
    bus.spawn_ready = 3'b001;
    @(negedge clock);
    bus.spawn_ready = '1;
    checks++;
    if (bus.spawn_valid !== 3'b000 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL hold_release: got valid=%b state=%0d, want 000 %0d",
               bus.spawn_valid, dbg_state, IDLE);
    end
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (step_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL disabled_quiet: got ticks=%0d state=%0d, want 0 %0d", ticks, dbg_state, IDLE);
    end
  endtask

  task automatic test_reset_in_issue();
    int n;
    do_reset();
    bus.col_busy = '0;
    bus.spawn_ready = '0;
    exp_q.push_back(3'b001);
    enable = 1'b1;
    wait_valid(n);
    checks++;
    if (n < 0) begin
      failures++;
      $display("FAIL rst_issue_timeout: got no spawn, want 001");
    end
    reset_signal = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.spawn_valid !== 3'b000 || step_tick !== 1'b0 || level !== 4'd0 ||
        dbg_lfsr !== 8'hA5 || dbg_state !== IDLE || dbg_rr_ptr !== 2'd0) begin
      failures++;
      $display("FAIL rst_in_issue: got valid=%b tick=%b level=%0d lfsr=%h state=%0d rr=%0d, want 000 0 0 a5 0 0",
               bus.spawn_valid, step_tick, level, dbg_lfsr, dbg_state, dbg_rr_ptr);
    end
    reset_signal = 1'b0;
    enable = 1'b0;
    bus.spawn_ready = '1;
    bus.col_busy = '1;
  endtask

`ifdef DROP_SCHED_PAUSE_EN
  task automatic test_pause();
    int ticks;
    do_reset();
    pause = 1'b1;
    enable = 1'b1;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (step_tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL pause_hold: got ticks=%0d state=%0d, want 0 %0d", ticks, dbg_state, IDLE);
    end
    pause = 1'b0;
    enable = 1'b0;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_first_spawn();
    test_level_speed();
    test_round_robin();
    test_all_busy();
    test_hold_enable_drop();
    test_reset_in_issue();
`ifdef DROP_SCHED_PAUSE_EN
    test_pause();
`endif
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending spawns, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
